// File: rtl/alu16_seq_if.sv
// rtl/alu16_seq_if.sv - shared types and bus interface for the 16-bit ALU sequencer
package alu16_seq_pkg;

    typedef logic [7:0] data_t;

    // SM83 F register layout: Z N H C in bits 7..4, low nibble always zero
    typedef struct packed {
        logic       z;
        logic       n;
        logic       h;
        logic       c;
        logic [3:0] rsvd;
    } flags_t;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_ADC = 4'd2,
        ALU_SUB = 4'd3,
        ALU_SBC = 4'd4,
        ALU_AND = 4'd5,
        ALU_XOR = 4'd6,
        ALU_OR  = 4'd7,
        ALU_CP  = 4'd8,
        ALU_INC = 4'd9,
        ALU_DEC = 4'd10
    } alu_op_t;

    localparam logic [1:0] OP_ADD16     = 2'b00;
    localparam logic [1:0] OP_ADD_SP_E8 = 2'b01;
    localparam logic [1:0] OP_INC16     = 2'b10;
    localparam logic [1:0] OP_DEC16     = 2'b11;

endpackage

interface alu16_seq_if;
    import alu16_seq_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    flags_t      req_flags;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    flags_t      rsp_flags;

    logic        alu_own;
    data_t       alu_op1;
    data_t       alu_op2;
    flags_t      alu_in_flags;
    alu_op_t     alu_op_o;
    data_t       alu_result;
    flags_t      alu_flags;

    // core side: issues requests, consumes responses, hosts the 8-bit ALU
    modport master (
        output req_valid, req_op, req_a, req_b, req_flags, rsp_ready, alu_result, alu_flags,
        input  req_ready, rsp_valid, rsp_result, rsp_flags,
        input  alu_own, alu_op1, alu_op2, alu_in_flags, alu_op_o
    );

    // sequencer side
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_flags, rsp_ready, alu_result, alu_flags,
        output req_ready, rsp_valid, rsp_result, rsp_flags,
        output alu_own, alu_op1, alu_op2, alu_in_flags, alu_op_o
    );

endinterface

// File: rtl/alu16_seq.sv
// rtl/alu16_seq.sv - two-pass 16-bit operation sequencer driving the 8-bit SM83 ALU
module alu16_seq #(
    parameter bit IDLE_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    alu16_seq_if.slave   bus
);
    import alu16_seq_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [1:0]  op_q;
    logic [15:0] a_q;
    logic [15:0] b_q;
    flags_t      flags_q;

    data_t       lo_res_q;
    flags_t      lo_flags_q;

    logic [15:0] rsp_result_q;
    flags_t      rsp_flags_q;

    data_t       hold_op1_q;
    data_t       hold_op2_q;
    logic        hold_c_q;
    alu_op_t     hold_op_q;

    data_t       drv_op1;
    data_t       drv_op2;
    logic        drv_c;
    alu_op_t     drv_op;
    logic        own;
    logic        accept;
    flags_t      merged;

    // Z, N and the reserved bits of the ALU flags play no part in any merge
    logic        alu_flags_unused;
    assign alu_flags_unused = ^{bus.alu_flags.z, bus.alu_flags.n, bus.alu_flags.rsvd};

    assign own           = (state_q == S_LO) || (state_q == S_HI);
    assign accept        = (state_q == S_IDLE) && bus.req_valid;
    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.alu_own   = own;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_flags  = rsp_flags_q;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: one cycle per byte pass, then wait for the consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.req_valid) state_d = S_LO;
            S_LO:    state_d = S_HI;
            S_HI:    state_d = S_DONE;
            S_DONE:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // per-pass ALU operands; ADC/SBC on the high byte carry the low-byte C across
    always_comb begin
        drv_op1 = 8'h00;
        drv_op2 = 8'h00;
        drv_c   = 1'b0;
        drv_op  = ALU_NOP;
        if (state_q == S_LO) begin
            drv_op1 = a_q[7:0];
            case (op_q)
                OP_ADD16:     begin drv_op = ALU_ADD; drv_op2 = b_q[7:0]; end
                OP_ADD_SP_E8: begin drv_op = ALU_ADD; drv_op2 = b_q[7:0]; end
                OP_INC16:     begin drv_op = ALU_ADD; drv_op2 = 8'h01;    end
                default:      begin drv_op = ALU_SUB; drv_op2 = 8'h01;    end
            endcase
        end else if (state_q == S_HI) begin
            drv_op1 = a_q[15:8];
            drv_c   = lo_flags_q.c;
            case (op_q)
                OP_ADD16:     begin drv_op = ALU_ADC; drv_op2 = b_q[15:8];      end
                OP_ADD_SP_E8: begin drv_op = ALU_ADC; drv_op2 = {8{b_q[7]}};    end
                OP_INC16:     begin drv_op = ALU_ADC; drv_op2 = 8'h00;          end
                default:      begin drv_op = ALU_SBC; drv_op2 = 8'h00;          end
            endcase
        end
    end

    // ALU drive: live while owning, otherwise zeroed or held at the last pass
    always_comb begin
        bus.alu_in_flags = '0;
        if (own) begin
            bus.alu_op1        = drv_op1;
            bus.alu_op2        = drv_op2;
            bus.alu_in_flags.c = drv_c;
            bus.alu_op_o       = drv_op;
        end else if (IDLE_ZERO) begin
            bus.alu_op1  = 8'h00;
            bus.alu_op2  = 8'h00;
            bus.alu_op_o = ALU_NOP;
        end else begin
            bus.alu_op1        = hold_op1_q;
            bus.alu_op2        = hold_op2_q;
            bus.alu_in_flags.c = hold_c_q;
            bus.alu_op_o       = hold_op_q;
        end
    end

    // final flag merge, evaluated during HI with the high-pass ALU flags live
    always_comb begin
        merged = '0;
        case (op_q)
            OP_ADD16: begin
                merged.z = flags_q.z;
                merged.h = bus.alu_flags.h;
                merged.c = bus.alu_flags.c;
            end
            OP_ADD_SP_E8: begin
                merged.h = lo_flags_q.h;
                merged.c = lo_flags_q.c;
            end
            default: merged = flags_q;
        endcase
    end

    // request capture, per-pass result capture and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q         <= 2'b00;
            a_q          <= 16'h0000;
            b_q          <= 16'h0000;
            flags_q      <= '0;
            lo_res_q     <= 8'h00;
            lo_flags_q   <= '0;
            rsp_result_q <= 16'h0000;
            rsp_flags_q  <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.req_op;
                a_q     <= bus.req_a;
                b_q     <= bus.req_b;
                flags_q <= bus.req_flags;
            end
            if (state_q == S_LO) begin
                lo_res_q   <= bus.alu_result;
                lo_flags_q <= bus.alu_flags;
            end
            if (state_q == S_HI) begin
                rsp_result_q <= {bus.alu_result, lo_res_q};
                rsp_flags_q  <= merged;
            end
        end
    end

    // last ALU drive values, used when IDLE_ZERO=0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_op1_q <= 8'h00;
            hold_op2_q <= 8'h00;
            hold_c_q   <= 1'b0;
            hold_op_q  <= ALU_NOP;
        end else if (own) begin
            hold_op1_q <= drv_op1;
            hold_op2_q <= drv_op2;
            hold_c_q   <= drv_c;
            hold_op_q  <= drv_op;
        end
    end

endmodule

// File: tb/tb_alu16_seq.sv
// tb/tb_alu16_seq.sv - directed self-checking bench for alu16_seq
module tb_alu16_seq;
    import alu16_seq_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    alu16_seq_if bus ();

    alu16_seq #(.IDLE_ZERO(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // reference 8-bit SM83 ALU (ADD/ADC/SUB/SBC only)
    logic [8:0] m_sum;
    logic [4:0] m_half;
    logic [7:0] m_cin;
    always_comb begin
        m_sum  = 9'h000;
        m_half = 5'h00;
        m_cin  = 8'h00;
        bus.alu_result = 8'h00;
        bus.alu_flags  = '0;
        if (bus.alu_op_o == ALU_ADC || bus.alu_op_o == ALU_SBC)
            m_cin = {7'b0, bus.alu_in_flags.c};
        case (bus.alu_op_o)
            ALU_ADD, ALU_ADC: begin
                m_sum  = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2} + {1'b0, m_cin};
                m_half = {1'b0, bus.alu_op1[3:0]} + {1'b0, bus.alu_op2[3:0]} + m_cin[4:0];
                bus.alu_result  = m_sum[7:0];
                bus.alu_flags.z = (m_sum[7:0] == 8'h00);
                bus.alu_flags.h = m_half[4];
                bus.alu_flags.c = m_sum[8];
            end
            ALU_SUB, ALU_SBC: begin
                m_sum  = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2} - {1'b0, m_cin};
                m_half = {1'b0, bus.alu_op1[3:0]} - {1'b0, bus.alu_op2[3:0]} - m_cin[4:0];
                bus.alu_result  = m_sum[7:0];
                bus.alu_flags.z = (m_sum[7:0] == 8'h00);
                bus.alu_flags.n = 1'b1;
                bus.alu_flags.h = m_half[4];
                bus.alu_flags.c = m_sum[8];
            end
            default: ;
        endcase
    end

    // issue one request with rsp_ready=1, count edges until rsp_valid is seen
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f, output int lat, output logic [15:0] res,
                          output logic [7:0] fl);
        @(negedge clk);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_flags = f;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            @(negedge clk);
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
        end
        res = bus.rsp_result;
        fl  = bus.rsp_flags;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.alu_own !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b valid=%b own=%b want 1 0 0",
                     bus.req_ready, bus.rsp_valid, bus.alu_own);
        end
        total++;
        if (bus.rsp_result !== 16'h0000 || bus.rsp_flags !== 8'h00) begin
            bad++;
            $display("FAIL reset_rsp: result=%h flags=%h want 0000 00", bus.rsp_result, bus.rsp_flags);
        end
        total++;
        if (bus.alu_op_o !== ALU_NOP || bus.alu_op1 !== 8'h00 || bus.alu_op2 !== 8'h00 ||
            bus.alu_in_flags !== 8'h00) begin
            bad++;
            $display("FAIL reset_alu: op=%h op1=%h op2=%h inf=%h want 0 00 00 00",
                     bus.alu_op_o, bus.alu_op1, bus.alu_op2, bus.alu_in_flags);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add16();
        int lat;
        logic [15:0] res;
        logic [7:0] fl;
        run_op(OP_ADD16, 16'h0FFF, 16'h0001, 8'h80, lat, res, fl);
        total++;
        if (lat !== 3) begin
            bad++;
            $display("FAIL add16_latency: got %0d want 3", lat);
        end
        total++;
        if (res !== 16'h1000 || fl !== 8'hA0) begin
            bad++;
            $display("FAIL add16_0fff: result=%h flags=%h want 1000 a0", res, fl);
        end
        run_op(OP_ADD16, 16'h8000, 16'h8000, 8'h00, lat, res, fl);
        total++;
        if (res !== 16'h0000 || fl !== 8'h10) begin
            bad++;
            $display("FAIL add16_8000: result=%h flags=%h want 0000 10", res, fl);
        end
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.alu_own !== 1'b0 || bus.alu_op_o !== ALU_NOP ||
            bus.alu_op1 !== 8'h00) begin
            bad++;
            $display("FAIL idle_zero: ready=%b own=%b op=%h op1=%h want 1 0 0 00",
                     bus.req_ready, bus.alu_own, bus.alu_op_o, bus.alu_op1);
        end
    endtask

    task automatic test_add_sp_e8();
        int lat;
        logic [15:0] res;
        logic [7:0] fl;
        run_op(OP_ADD_SP_E8, 16'h00FF, 16'h0001, 8'hF0, lat, res, fl);
        total++;
        if (res !== 16'h0100 || fl !== 8'h30) begin
            bad++;
            $display("FAIL addsp_pos: result=%h flags=%h want 0100 30", res, fl);
        end
        run_op(OP_ADD_SP_E8, 16'h0000, 16'hAAFF, 8'hF0, lat, res, fl);
        total++;
        if (res !== 16'hFFFF || fl !== 8'h00) begin
            bad++;
            $display("FAIL addsp_neg: result=%h flags=%h want ffff 00", res, fl);
        end
    endtask

    task automatic test_inc_dec();
        int lat;
        logic [15:0] res;
        logic [7:0] fl;
        run_op(OP_INC16, 16'hFFFF, 16'h1234, 8'hF0, lat, res, fl);
        total++;
        if (res !== 16'h0000 || fl !== 8'hF0) begin
            bad++;
            $display("FAIL inc16_wrap: result=%h flags=%h want 0000 f0", res, fl);
        end
        run_op(OP_DEC16, 16'h0000, 16'h0000, 8'h00, lat, res, fl);
        total++;
        if (res !== 16'hFFFF || fl !== 8'h00) begin
            bad++;
            $display("FAIL dec16_wrap: result=%h flags=%h want ffff 00", res, fl);
        end
        run_op(OP_INC16, 16'h12FF, 16'h0000, 8'h00, lat, res, fl);
        total++;
        if (res !== 16'h1300 || fl !== 8'h00) begin
            bad++;
            $display("FAIL inc16_carry: result=%h flags=%h want 1300 00", res, fl);
        end
        run_op(OP_DEC16, 16'h1200, 16'h0000, 8'hF0, lat, res, fl);
        total++;
        if (res !== 16'h11FF || fl !== 8'hF0) begin
            bad++;
            $display("FAIL dec16_borrow: result=%h flags=%h want 11ff f0", res, fl);
        end
    endtask

    task automatic test_backpressure();
        int stable_bad = 0;
        int seen = 0;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        bus.req_op    = OP_ADD16;
        bus.req_a     = 16'hF800;
        bus.req_b     = 16'h0900;
        bus.req_flags = 8'h00;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0100 || bus.rsp_flags !== 8'h30) begin
            bad++;
            $display("FAIL bp_first: valid=%b result=%h flags=%h want 1 0100 30",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
        end
        bus.req_op    = OP_DEC16;
        bus.req_a     = 16'h5555;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 16'h0100 ||
                bus.rsp_flags !== 8'h30 || bus.req_ready !== 1'b0 || bus.alu_own !== 1'b0)
                stable_bad++;
        end
        total++;
        if (stable_bad != 0) begin
            bad++;
            $display("FAIL bp_stable: %0d unstable cycles want 0 (result=%h flags=%h)",
                     stable_bad, bus.rsp_result, bus.rsp_flags);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_result !== 16'h0100) begin
            bad++;
            $display("FAIL bp_release: valid=%b ready=%b result=%h want 0 1 0100",
                     bus.rsp_valid, bus.req_ready, bus.rsp_result);
        end
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0 || bus.alu_own !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL bp_not_queued: %0d busy cycles want 0", seen);
        end
    endtask

    task automatic test_reset_mid_op();
        int pulses = 0;
        @(negedge clk);
        bus.req_op    = OP_INC16;
        bus.req_a     = 16'h00FF;
        bus.req_flags = 8'h00;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.alu_own !== 1'b1 || bus.alu_op_o !== ALU_ADC) begin
            bad++;
            $display("FAIL hi_pass: own=%b op=%h want 1 %h", bus.alu_own, bus.alu_op_o, ALU_ADC);
        end
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1 || bus.alu_own !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.alu_op_o !== ALU_NOP) begin
            bad++;
            $display("FAIL rst_abort: ready=%b own=%b valid=%b op=%h want 1 0 0 0",
                     bus.req_ready, bus.alu_own, bus.rsp_valid, bus.alu_op_o);
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL rst_no_rsp: %0d rsp_valid cycles want 0", pulses);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_a     = 16'h0000;
        bus.req_b     = 16'h0000;
        bus.req_flags = 8'h00;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_add16();
        test_add_sp_e8();
        test_inc_dec();
        test_backpressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
